eth_byte_bridge: RTL

Byte-level buffering stage between the Ethernet MAC byte streams and the protocol engine's read/write byte interface.
- RX side: captures MAC receive bytes into a FIFO and answers the protocol engine's read requests one byte at a time.
- TX side: accepts bytes from the protocol engine into a FIFO and drains them to the MAC transmit stream with valid/ready flow control.
- The task-level FSM flushes both directions on link loss.

---
 rtl/eth_byte_bridge_if.sv | 47 ++++
 rtl/eth_byte_bridge.sv | 131 +++++++++++++
 2 files changed

// File: rtl/eth_byte_bridge_if.sv
// ----------------------------------------------------------------------------
// eth_byte_bridge_if
// Groups the byte-stream and handshake signals of eth_byte_bridge.
//   slave  modport : the bridge itself (consumes i_*, drives o_*)
//   master modport : the surrounding logic (MAC + protocol engine side)
// Signals:
//   i_flush                         synchronous clear of both directions
//   i_mac_rx_data / i_mac_rx_valid  MAC receive byte stream (no backpressure)
//   i_rreq / o_rdata / o_rready     protocol read request and one-cycle reply
//   i_wdata / i_wvalid / o_wready   protocol write byte and acceptance
//   o_mac_tx_data / o_mac_tx_valid / i_mac_tx_ready   MAC transmit stream
//   o_rx_level / o_rx_overflow      RX occupancy and sticky drop flag
// ----------------------------------------------------------------------------
interface eth_byte_bridge_if #(
    parameter int RX_DEPTH = 16
) ();
    localparam int LVL_W = $clog2(RX_DEPTH) + 1;

    logic             i_flush;
    logic [7:0]       i_mac_rx_data;
    logic             i_mac_rx_valid;
    logic             i_rreq;
    logic [7:0]       o_rdata;
    logic             o_rready;
    logic [7:0]       i_wdata;
    logic             i_wvalid;
    logic             o_wready;
    logic [7:0]       o_mac_tx_data;
    logic             o_mac_tx_valid;
    logic             i_mac_tx_ready;
    logic [LVL_W-1:0] o_rx_level;
    logic             o_rx_overflow;

    modport slave (
        input  i_flush, i_mac_rx_data, i_mac_rx_valid, i_rreq,
               i_wdata, i_wvalid, i_mac_tx_ready,
        output o_rdata, o_rready, o_wready, o_mac_tx_data, o_mac_tx_valid,
               o_rx_level, o_rx_overflow
    );

    modport master (
        output i_flush, i_mac_rx_data, i_mac_rx_valid, i_rreq,
               i_wdata, i_wvalid, i_mac_tx_ready,
        input  o_rdata, o_rready, o_wready, o_mac_tx_data, o_mac_tx_valid,
               o_rx_level, o_rx_overflow
    );
endinterface

// File: rtl/eth_byte_bridge.sv
// ----------------------------------------------------------------------------
// eth_byte_bridge
// Byte buffering between the Ethernet MAC streams and the protocol engine.
//   RX: MAC bytes are queued in an RX FIFO; a registered read handshake
//       returns one byte per request (o_rready pulse with o_rdata).
//   TX: protocol bytes are queued in a TX FIFO and presented to the MAC
//       first-word-fall-through with valid/ready flow control.
// Ports:
//   i_clk  clock
//   i_rst  synchronous active-high reset
//   bus    eth_byte_bridge_if.slave (all data/handshake signals, i_flush)
// ----------------------------------------------------------------------------
module eth_byte_bridge #(
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    eth_byte_bridge_if.slave  bus
);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int RX_CW = RX_AW + 1;
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int TX_CW = TX_AW + 1;
    localparam logic [RX_CW-1:0] RX_FULL = RX_CW'(RX_DEPTH);
    localparam logic [TX_CW-1:0] TX_FULL = TX_CW'(TX_DEPTH);

    typedef enum logic {RD_IDLE, RD_PEND} rd_state_e;

    // Flush behaves exactly like reset and wins over any same-cycle event.
    logic clr;
    assign clr = i_rst | bus.i_flush;

    // ---------------- RX side ----------------
    rd_state_e        rd_state_q, rd_state_d;
    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
    logic [RX_CW-1:0] rx_count_q, rx_count_d;
    logic             rx_push, rx_pop, rx_drop;
    logic             rx_ovf_q, rready_q;
    logic [7:0]       rdata_q;

    // Read-request FSM: state register
    always_ff @(posedge i_clk) begin
        if (clr) rd_state_q <= RD_IDLE;
        else     rd_state_q <= rd_state_d;
    end

    // Read-request FSM: next state. A request seen while a pop happens is
    // either the one being served or one arriving while pending -- both drop.
    always_comb begin
        rd_state_d = rd_state_q;
        if (rx_pop)          rd_state_d = RD_IDLE;
        else if (bus.i_rreq) rd_state_d = RD_PEND;
    end

    // Read-request FSM: outputs. A request sampled this edge counts as pending.
    always_comb begin
        rx_pop = 1'b0;
        if (!clr && (rd_state_q == RD_PEND || bus.i_rreq) && rx_count_q != '0)
            rx_pop = 1'b1;
    end

    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign rx_push    = ~clr & bus.i_mac_rx_valid & ((rx_count_q != RX_FULL) | rx_pop);
    assign rx_drop    = ~clr & bus.i_mac_rx_valid & ~rx_push;
    assign rx_count_d = rx_count_q + RX_CW'(rx_push) - RX_CW'(rx_pop);

    always_ff @(posedge i_clk) begin
        if (clr) begin
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_count_q  <= '0;
            rx_ovf_q    <= 1'b0;
            rready_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + RX_AW'(1);
            if (rx_pop) begin
                rx_rd_ptr_q <= rx_rd_ptr_q + RX_AW'(1);
                rdata_q     <= rx_mem[rx_rd_ptr_q];
            end
            rready_q   <= rx_pop;
            rx_count_q <= rx_count_d;
            if (rx_drop) rx_ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (rx_push) rx_mem[rx_wr_ptr_q] <= bus.i_mac_rx_data;
    end

    assign bus.o_rdata       = rdata_q;
    assign bus.o_rready      = rready_q;
    assign bus.o_rx_level    = rx_count_q;
    assign bus.o_rx_overflow = rx_ovf_q;

    // ---------------- TX side ----------------
    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
    logic [TX_CW-1:0] tx_count_q, tx_count_d;
    logic             tx_wready, tx_push, tx_pop;

    // Write acceptance looks only at the registered count, so a drain in the
    // same cycle does not free a slot for a write to a full FIFO.
    assign tx_wready  = (tx_count_q != TX_FULL);
    assign tx_push    = ~clr & bus.i_wvalid & tx_wready;
    assign tx_pop     = ~clr & (tx_count_q != '0) & bus.i_mac_tx_ready;
    assign tx_count_d = tx_count_q + TX_CW'(tx_push) - TX_CW'(tx_pop);

    always_ff @(posedge i_clk) begin
        if (clr) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_count_q  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + TX_AW'(1);
            if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + TX_AW'(1);
            tx_count_q <= tx_count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (tx_push) tx_mem[tx_wr_ptr_q] <= bus.i_wdata;
    end

    assign bus.o_wready       = tx_wready;
    assign bus.o_mac_tx_valid = (tx_count_q != '0);
    assign bus.o_mac_tx_data  = tx_mem[tx_rd_ptr_q];

endmodule
